// File: rtl/carry_lookahead_adder_4bits.sv
// carry_lookahead_adder_4bits
// Registered 4-bit carry-lookahead adder. Every carry is a flat
// sum-of-products of the bit generate/propagate terms and Cin, so there
// is no ripple chain. Results are registered, with a one-cycle valid
// pipeline.
//
// Optional build macro: CLA_GROUP_PG_EN
//   defined   : registered group propagate/generate (Pg/Gg) for a
//               second-level lookahead unit
//   undefined : Pg/Gg stay as ports, tied to 0, and have no registers
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   A, B       4-bit operands (unsigned or two's complement)
//   Cin        carry-in
//   in_valid   operands valid this cycle
//   C          registered sum
//   Cout       registered carry-out of bit 3
//   Ovf        registered signed overflow
//   out_valid  C/Cout/Ovf hold a new result
//   Pg, Gg     registered group propagate / generate (independent of Cin)
module carry_lookahead_adder_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       in_valid,
  output logic [3:0] C,
  output logic       Cout,
  output logic       Ovf,
  output logic       out_valid,
  output logic       Pg,
  output logic       Gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] sum;

  always_comb begin
    g = A & B;
    p = A ^ B;

    // Two-level carries: every c[i] is built from g/p and Cin only.
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

    sum = p ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C         <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        C    <= sum;
        Cout <= c[4];
        Ovf  <= c[4] ^ c[3];
      end
    end
  end

`ifdef CLA_GROUP_PG_EN
  logic pg_grp;
  logic gg_grp;

  always_comb begin
    pg_grp = &p;
    gg_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pg <= 1'b0;
      Gg <= 1'b0;
    end else if (in_valid) begin
      Pg <= pg_grp;
      Gg <= gg_grp;
    end
  end
`else
  assign Pg = 1'b0;
  assign Gg = 1'b0;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_4bits.sv
// Self-checking bench for carry_lookahead_adder_4bits. The reference
// model works from plain integer addition and operand signs; it follows
// whichever CLA_GROUP_PG_EN build is compiled.
module tb_carry_lookahead_adder_4bits;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       in_valid;
  logic [3:0] C;
  logic       Cout;
  logic       Ovf;
  logic       out_valid;
  logic       Pg;
  logic       Gg;

  int unsigned errors;
  int unsigned checks;

  // Reference model state (expected registered outputs)
  logic [3:0] m_c;
  logic       m_cout;
  logic       m_ovf;
  logic       m_valid;
  logic       m_pg;
  logic       m_gg;

  carry_lookahead_adder_4bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .C         (C),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .out_valid (out_valid),
    .Pg        (Pg),
    .Gg        (Gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string field,
                       input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check(tag, "out_valid", {3'b0, out_valid}, {3'b0, m_valid});
    check(tag, "C",         C,                 m_c);
    check(tag, "Cout",      {3'b0, Cout},      {3'b0, m_cout});
    check(tag, "Ovf",       {3'b0, Ovf},       {3'b0, m_ovf});
    check(tag, "Pg",        {3'b0, Pg},        {3'b0, m_pg});
    check(tag, "Gg",        {3'b0, Gg},        {3'b0, m_gg});
  endtask

  task automatic model_reset();
    m_c     = '0;
    m_cout  = 1'b0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_pg    = 1'b0;
    m_gg    = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, update the model, and
  // check the registered outputs just after the following rising edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic v);
    int unsigned total;
    int          sa;
    int          sb;
    int          ssum;
    @(negedge clk);
    A        = a;
    B        = b;
    Cin      = ci;
    in_valid = v;
    m_valid  = v;
    if (v) begin
      total  = int'(a) + int'(b) + int'(ci);
      m_c    = total[3:0];
      m_cout = (total > 15);
      sa     = a[3] ? int'(a) - 16 : int'(a);
      sb     = b[3] ? int'(b) - 16 : int'(b);
      ssum   = sa + sb + int'(ci);
      m_ovf  = (ssum > 7) || (ssum < -8);
`ifdef CLA_GROUP_PG_EN
      m_pg   = ((a ^ b) == 4'hF);
      m_gg   = (int'(a) + int'(b) > 15);
`else
      m_pg   = 1'b0;
      m_gg   = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();

    // Reset held across an edge with live inputs: nothing loads
    rst_n    = 1'b0;
    A        = 4'h5;
    B        = 4'h7;
    Cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sums
    step("zero",        4'b0000, 4'b0000, 1'b0, 1'b1);
    step("basic_0001",  4'b0001, 4'b0100, 1'b0, 1'b1);
    step("prop_nocin",  4'b1100, 4'b0011, 1'b0, 1'b1);
    step("all_ones",    4'b1111, 4'b1111, 1'b1, 1'b1);
    step("chain_1101",  4'b1101, 4'b0011, 1'b1, 1'b1);
    step("prop_cin",    4'b1100, 4'b0011, 1'b1, 1'b1);
    step("ovf_pos",     4'b0111, 4'b0001, 1'b0, 1'b1);
    step("ovf_neg",     4'b1000, 4'b1000, 1'b0, 1'b1);

    // Valid gating 1,0,1: result held through the idle cycle
    step("gate_v1",     4'b0110, 4'b0101, 1'b1, 1'b1);
    step("gate_v0",     4'b1111, 4'b0001, 1'b0, 1'b0);
    step("gate_v1b",    4'b0010, 4'b0011, 1'b0, 1'b1);

    // Inputs moving between edges must not reach the outputs
    #2;
    A   = ~A;
    B   = 4'hF;
    Cin = 1'b1;
    #1;
    check_all("between_edges");

    // Asynchronous reset mid-stream discards the pending operation
    step("pre_reset",   4'b1001, 4'b1010, 1'b1, 1'b1);
    @(negedge clk);
    A        = 4'h9;
    B        = 4'h9;
    Cin      = 1'b0;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset",  4'b0011, 4'b0100, 1'b1, 1'b1);

    // Exhaustive sweep, back-to-back valid
    for (int unsigned i = 0; i < 512; i++) begin
      logic [8:0] vec;
      vec = 9'(i);
      step("sweep", vec[3:0], vec[7:4], vec[8], 1'b1);
    end

    // Random operands with random valid gaps
    for (int unsigned i = 0; i < 200; i++) begin
      step("random", 4'($urandom), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
